// File: rtl/m20k_dp_bank.sv
// m20k_dp_bank: true dual-port M20K RAM bank with per-bit write masks, deterministic
// collision handling and a post-reset clear sequencer. Macro M20K_DP_BANK_OUTREG_EN adds an output register stage.
module m20k_dp_bank #(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned DEPTH          = 512,
  parameter int unsigned AW             = $clog2(DEPTH),
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [AW-1:0]    A0,
  input  logic [WIDTH-1:0] D0,
  input  logic             CE0,
  input  logic             WE0,
  input  logic [WIDTH-1:0] WEM0,
  output logic [WIDTH-1:0] Q0,
  input  logic [AW-1:0]    A1,
  input  logic [WIDTH-1:0] D1,
  input  logic             CE1,
  input  logic             WE1,
  input  logic [WIDTH-1:0] WEM1,
  output logic [WIDTH-1:0] Q1,
  output logic             BUSY
);

  typedef enum logic [1:0] {S_CLEAR, S_DONE_WAIT, S_IDLE} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] cnt, cnt_nxt;
  logic          busy_nxt;

  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0]    addr [2];
  logic [WIDTH-1:0] din  [2];
  logic [WIDTH-1:0] wem  [2];
  logic [1:0]       ce, we, in_range, wr, rd;

  logic [AW-1:0]    rd_addr [2];
  logic [1:0]       rd_fresh, rd_oob;
  logic [WIDTH-1:0] q_hold [2];
  logic [WIDTH-1:0] q_c    [2];

  assign addr[0] = A0;
  assign addr[1] = A1;
  assign din[0]  = D0;
  assign din[1]  = D1;
  assign wem[0]  = WEM0;
  assign wem[1]  = WEM1;
  assign ce      = {CE1, CE0};
  assign we      = {WE1, WE0};

  // Clear sequencer state register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= CLEAR_ON_RESET ? S_CLEAR : S_DONE_WAIT;
      cnt   <= '0;
      BUSY  <= 1'b1;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      BUSY  <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      S_CLEAR: begin
        cnt_nxt = cnt + AW'(1);
        if (cnt == AW'(DEPTH - 1)) begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
        end
      end
      S_DONE_WAIT: state_nxt = S_IDLE;
      default:     state_nxt = state;
    endcase
    busy_nxt = (state_nxt != S_IDLE);
  end

  // Access qualification: nothing reaches the array while the bank is busy
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      in_range[p] = ({1'b0, addr[p]} < (AW+1)'(DEPTH));
      rd[p]       = !BUSY && ce[p];
      wr[p]       = !BUSY && ce[p] && we[p] && in_range[p];
    end
  end

  // Array write port; port 0 is applied last so it owns every bit it masks in
  always_ff @(posedge CLK) begin
    if (state == S_CLEAR) begin
      mem[cnt] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (wr[1] && wem[1][i]) mem[addr[1]][i] <= din[1][i];
        if (wr[0] && wem[0][i]) mem[addr[0]][i] <= din[0][i];
      end
    end
  end

  // Registered read address plus a hold register so Q is stable when CE is low
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rd_fresh <= '0;
      rd_oob   <= '0;
      for (int p = 0; p < 2; p++) begin
        rd_addr[p] <= '0;
        q_hold[p]  <= '0;
      end
    end else begin
      rd_fresh <= rd;
      for (int p = 0; p < 2; p++) begin
        if (rd[p]) begin
          rd_addr[p] <= addr[p];
          rd_oob[p]  <= !in_range[p];
        end
        q_hold[p] <= q_c[p];
      end
    end
  end

  // The array output already reflects every write of the read edge, giving write-first forwarding
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      q_c[p] = q_hold[p];
      if (rd_fresh[p]) q_c[p] = rd_oob[p] ? '0 : mem[rd_addr[p]];
    end
  end

`ifdef M20K_DP_BANK_OUTREG_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      Q0 <= '0;
      Q1 <= '0;
    end else begin
      Q0 <= q_c[0];
      Q1 <= q_c[1];
    end
  end
`else
  assign Q0 = q_c[0];
  assign Q1 = q_c[1];
`endif

endmodule
